program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_next.sv | 34 +++
 rtl/program_sequencer.sv | 100 ++++++++++
 tb/tb_program_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared sequencer state encoding and width defaults
package cpu_pkg;

    localparam int SEQ_PC_WIDTH    = 6;
    localparam int SEQ_PROG_LEN    = 64;
    localparam int SEQ_STALL_WIDTH = 8;

    // Encoding 2'b11 is unused and is steered back to ST_START by the sequencer.
    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10
    } seq_state_e;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next program address: jump, branch, increment
module pc_next
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = SEQ_PC_WIDTH,
    parameter int PROG_LEN = SEQ_PROG_LEN
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                jump,
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] target,
    input  logic [PC_WIDTH-1:0] offset,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                inc_wrap
);

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_LEN - 1);

    // Jump beats branch beats increment; only the increment path may flag a wrap,
    // and branch sums are left to roll over modulo 2^PC_WIDTH.
    always_comb begin
        next_pc  = pc + PC_WIDTH'(1);
        inc_wrap = 1'b0;
        if (jump) begin
            next_pc = target;
        end else if (branch) begin
            next_pc = pc + offset;
        end else if (pc == LAST_PC) begin
            next_pc  = '0;
            inc_wrap = 1'b1;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program counter sequencer with stall handling
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = SEQ_PC_WIDTH,
    parameter int PROG_LEN    = SEQ_PROG_LEN,
    parameter int STALL_WIDTH = SEQ_STALL_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   halt_program,
    input  logic                   jump,
    input  logic                   branch,
    input  logic [PC_WIDTH-1:0]    target,
    input  logic [PC_WIDTH-1:0]    offset,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   commit,
    output logic                   wrap,
    output logic                   stalled,
    output logic [STALL_WIDTH-1:0] stall_cycles
);

    localparam logic [1:0] S_START = ST_START;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_STALL = ST_STALL;

    localparam logic [STALL_WIDTH-1:0] STALL_MAX = '1;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                active;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                inc_wrap;

    // The illegal encoding is treated like START so it can never retire an instruction.
    assign active = (state == S_RUN) || (state == S_STALL);
    assign commit = active && !halt_program;

    pc_next #(
        .PC_WIDTH (PC_WIDTH),
        .PROG_LEN (PROG_LEN)
    ) u_pc_next (
        .pc       (pc),
        .jump     (jump),
        .branch   (branch),
        .target   (target),
        .offset   (offset),
        .next_pc  (pc_nxt),
        .inc_wrap (inc_wrap)
    );

    // Next-state: START lasts one cycle, RUN/STALL follow halt_program.
    always_comb begin
        state_nxt = S_START;
        case (state)
            S_START: state_nxt = S_RUN;
            S_RUN:   state_nxt = halt_program ? S_STALL : S_RUN;
            S_STALL: state_nxt = halt_program ? S_STALL : S_RUN;
            default: state_nxt = S_START;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_START;
        end else begin
            state <= state_nxt;
        end
    end

    // Program counter advances only on commit; wrap is a one-cycle pulse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pc   <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= commit && inc_wrap;
            if (commit) begin
                pc <= pc_nxt;
            end
        end
    end

    // Stall flag mirrors the next state; stall counter saturates and clears after a commit.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stalled      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            stalled <= (state_nxt == S_STALL);
            if (commit) begin
                stall_cycles <= '0;
            end else if (active && halt_program && stall_cycles != STALL_MAX) begin
                stall_cycles <= stall_cycles + STALL_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer
module tb_program_sequencer;

    typedef struct packed {
        logic       halt;
        logic       jump;
        logic       branch;
        logic [5:0] target;
        logic [5:0] offset;
        logic       exp_commit;
        logic [5:0] exp_pc;
        logic       exp_wrap;
        logic       exp_stalled;
        logic [7:0] exp_sc;
    } vec_t;

    typedef struct packed {
        logic [5:0] pc;
        logic       wrap;
        logic       stalled;
        logic [7:0] sc;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       halt_program = 1'b0;
    logic       jump = 1'b0;
    logic       branch = 1'b0;
    logic [5:0] target = '0;
    logic [5:0] offset = '0;
    logic [5:0] pc;
    logic       commit;
    logic       wrap;
    logic       stalled;
    logic [7:0] stall_cycles;

    logic       n_reset4 = 1'b0;
    logic [5:0] pc4;
    logic       commit4;
    logic       wrap4;
    logic       stalled4;
    logic [7:0] sc4;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];
    vec_t tbl[21];

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .halt_program (halt_program),
        .jump         (jump),
        .branch       (branch),
        .target       (target),
        .offset       (offset),
        .pc           (pc),
        .commit       (commit),
        .wrap         (wrap),
        .stalled      (stalled),
        .stall_cycles (stall_cycles)
    );

    program_sequencer #(.PROG_LEN(4)) dut4 (
        .clk          (clk),
        .n_reset      (n_reset4),
        .halt_program (1'b0),
        .jump         (1'b0),
        .branch       (1'b0),
        .target       (6'd0),
        .offset       (6'd0),
        .pc           (pc4),
        .commit       (commit4),
        .wrap         (wrap4),
        .stalled      (stalled4),
        .stall_cycles (sc4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic h, input logic j, input logic b,
                                input logic [5:0] t, input logic [5:0] o,
                                input logic c, input logic [5:0] p, input logic w,
                                input logic s, input logic [7:0] sc);
        vec_t v;
        v.halt = h; v.jump = j; v.branch = b; v.target = t; v.offset = o;
        v.exp_commit = c; v.exp_pc = p; v.exp_wrap = w; v.exp_stalled = s; v.exp_sc = sc;
        return v;
    endfunction

    // Called at active edge + 1: drive, check commit, push, clock, pop and compare.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        halt_program = v.halt;
        jump         = v.jump;
        branch       = v.branch;
        target       = v.target;
        offset       = v.offset;
        #1;
        chk($sformatf("%s.commit", tag), 32'(commit), 32'(v.exp_commit));
        sb.push_back('{pc: v.exp_pc, wrap: v.exp_wrap, stalled: v.exp_stalled, sc: v.exp_sc});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("%s.pc", tag), 32'(pc), 32'(e.pc));
        chk($sformatf("%s.wrap", tag), 32'(wrap), 32'(e.wrap));
        chk($sformatf("%s.stalled", tag), 32'(stalled), 32'(e.stalled));
        chk($sformatf("%s.stall_cycles", tag), 32'(stall_cycles), 32'(e.sc));
    endtask

    task automatic step4(input logic c, input logic [5:0] p, input logic w, input int idx);
        exp_t e;
        chk($sformatf("len4_%0d.commit", idx), 32'(commit4), 32'(c));
        sb.push_back('{pc: p, wrap: w, stalled: 1'b0, sc: 8'd0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("len4_%0d.pc", idx), 32'(pc4), 32'(e.pc));
        chk($sformatf("len4_%0d.wrap", idx), 32'(wrap4), 32'(e.wrap));
        chk($sformatf("len4_%0d.stalled", idx), 32'(stalled4), 32'(e.stalled));
    endtask

    initial begin
        //            halt jmp br  target offset     commit pc  wrap stl sc
        tbl[0]  = mk(0, 0, 0, 6'd0,  6'd0,       0, 6'd0,  0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 6'd0,  6'd0,       1, 6'd1,  0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 6'd0,  6'd0,       1, 6'd2,  0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 6'd0,  6'd0,       1, 6'd3,  0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 6'd10, 6'd0,       1, 6'd10, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 6'd0,  6'b111101,  1, 6'd7,  0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 6'd20, 6'd5,       1, 6'd20, 0, 0, 0);
        tbl[7]  = mk(1, 1, 0, 6'd30, 6'd0,       0, 6'd20, 0, 1, 1);
        tbl[8]  = mk(0, 0, 1, 6'd0,  6'd3,       1, 6'd23, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 6'd63, 6'd0,       1, 6'd63, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 6'd0,  6'd0,       1, 6'd0,  1, 0, 0);
        tbl[11] = mk(0, 0, 0, 6'd0,  6'd0,       1, 6'd1,  0, 0, 0);
        tbl[12] = mk(0, 1, 0, 6'd60, 6'd0,       1, 6'd60, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 6'd0,  6'd10,      1, 6'd6,  0, 0, 0);
        tbl[14] = mk(0, 1, 0, 6'd63, 6'd0,       1, 6'd63, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 6'd0,  6'd0,       1, 6'd0,  0, 0, 0);
        tbl[16] = mk(0, 1, 0, 6'd62, 6'd0,       1, 6'd62, 0, 0, 0);
        tbl[17] = mk(0, 0, 1, 6'd0,  6'd2,       1, 6'd0,  0, 0, 0);
        tbl[18] = mk(1, 0, 0, 6'd0,  6'd0,       0, 6'd0,  0, 1, 1);
        tbl[19] = mk(1, 0, 1, 6'd0,  6'd5,       0, 6'd0,  0, 1, 2);
        tbl[20] = mk(0, 0, 0, 6'd0,  6'd0,       1, 6'd1,  0, 0, 0);

        // Reset state while n_reset is held low.
        #2;
        chk("rst.pc", 32'(pc), 32'd0);
        chk("rst.commit", 32'(commit), 32'd0);
        chk("rst.wrap", 32'(wrap), 32'd0);
        chk("rst.stalled", 32'(stalled), 32'd0);
        chk("rst.stall_cycles", 32'(stall_cycles), 32'd0);

        @(posedge clk);
        #1;
        n_reset = 1'b1;
        for (int i = 0; i < 21; i++) begin
            step(tbl[i], $sformatf("v%0d", i));
        end

        // Long stall at pc=5: counter saturates, release commits in the same cycle.
        step(mk(0, 1, 0, 6'd5, 6'd0, 1, 6'd5, 0, 0, 0), "to5");
        for (int i = 0; i < 300; i++) begin
            step(mk(1, 0, 0, 6'd0, 6'd0, 0, 6'd5, 0, 1, (i + 1 > 255) ? 8'd255 : 8'(i + 1)),
                 $sformatf("sat%0d", i));
        end
        step(mk(0, 0, 0, 6'd0, 6'd0, 1, 6'd6, 0, 0, 0), "sat_rel");

        // Reset pulsed mid-cycle during a stall at pc=9.
        step(mk(0, 1, 0, 6'd9, 6'd0, 1, 6'd9, 0, 0, 0), "to9");
        for (int i = 0; i < 12; i++) begin
            step(mk(1, 1, 1, 6'd30, 6'd4, 0, 6'd9, 0, 1, 8'(i + 1)), $sformatf("st9_%0d", i));
        end
        #4;
        n_reset = 1'b0;
        #1;
        chk("midrst.pc", 32'(pc), 32'd0);
        chk("midrst.stall_cycles", 32'(stall_cycles), 32'd0);
        chk("midrst.stalled", 32'(stalled), 32'd0);
        chk("midrst.commit", 32'(commit), 32'd0);
        halt_program = 1'b0;
        jump = 1'b0;
        branch = 1'b0;
        #2;
        n_reset = 1'b1;
        #1;
        chk("midrst.start_commit", 32'(commit), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst.run_pc", 32'(pc), 32'd0);
        step(mk(0, 0, 0, 6'd0, 6'd0, 1, 6'd1, 0, 0, 0), "postrst");

        // PROG_LEN=4 free run: 0,1,2,3,0 with wrap only after 3 -> 0.
        n_reset4 = 1'b1;
        #1;
        step4(0, 6'd0, 0, 0);
        step4(1, 6'd1, 0, 1);
        step4(1, 6'd2, 0, 2);
        step4(1, 6'd3, 0, 3);
        step4(1, 6'd0, 1, 4);
        step4(1, 6'd1, 0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
